// File: rtl/bcd_scan_display_if.sv
// Bus between a BCD digit source and the scanned 7-segment driver.
// Handshake: load is a one-cycle strobe that is always accepted (no ready); digits are sampled only when load=1.
interface bcd_scan_display_if;
  logic       load;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_done;
  logic [1:0] dbg_slot;

  modport master (
    output load, hundreds, tens, ones,
    input  seg, an, dp, frame_done, dbg_slot
  );

  modport slave (
    input  load, hundreds, tens, ones,
    output seg, an, dp, frame_done, dbg_slot
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with double-buffered BCD digits.
// Optional leading-zero blanking when the LZB_EN macro is defined.
module bcd_scan_display #(
  parameter int REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst_n,
  bcd_scan_display_if.slave bus
);

  localparam int              PW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    SLOT_ONES  = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_HUND  = 2'd2,
    SLOT_BLANK = 2'd3
  } slot_t;

  logic [PW-1:0] r_presc;
  slot_t         r_slot;
  slot_t         w_slot_next;
  logic          w_tick;
  logic          w_commit;

  logic          r_pend_flag;
  logic [3:0]    r_pend_h, r_pend_t, r_pend_o;
  logic [3:0]    r_shd_h, r_shd_t, r_shd_o;

  logic [3:0]    w_an_next;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic          w_lzb_h, w_lzb_t;

  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_frame_done;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;
    endcase
  endfunction

  assign w_tick   = (r_presc == LAST);
  assign w_commit = w_tick && (r_slot == SLOT_BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_presc <= '0;
    else        r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end

  // Slot scan state machine: state register plus next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_slot <= SLOT_ONES;
    else        r_slot <= w_slot_next;
  end

  always_comb begin
    w_slot_next = r_slot;
    if (w_tick) begin
      case (r_slot)
        SLOT_ONES: w_slot_next = SLOT_TENS;
        SLOT_TENS: w_slot_next = SLOT_HUND;
        SLOT_HUND: w_slot_next = SLOT_BLANK;
        default:   w_slot_next = SLOT_ONES;
      endcase
    end
  end

  // A load landing on the frame boundary bypasses pending so it shows in the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_flag <= 1'b0;
      r_pend_h    <= '0;
      r_pend_t    <= '0;
      r_pend_o    <= '0;
      r_shd_h     <= '0;
      r_shd_t     <= '0;
      r_shd_o     <= '0;
    end else if (bus.load && w_commit) begin
      r_shd_h     <= bus.hundreds;
      r_shd_t     <= bus.tens;
      r_shd_o     <= bus.ones;
      r_pend_flag <= 1'b0;
    end else if (bus.load) begin
      r_pend_h    <= bus.hundreds;
      r_pend_t    <= bus.tens;
      r_pend_o    <= bus.ones;
      r_pend_flag <= 1'b1;
    end else if (w_commit && r_pend_flag) begin
      r_shd_h     <= r_pend_h;
      r_shd_t     <= r_pend_t;
      r_shd_o     <= r_pend_o;
      r_pend_flag <= 1'b0;
    end
  end

`ifdef LZB_EN
  assign w_lzb_h = (r_shd_h == 4'd0);
  assign w_lzb_t = w_lzb_h && (r_shd_t == 4'd0);
`else
  assign w_lzb_h = 1'b0;
  assign w_lzb_t = 1'b0;
`endif

  always_comb begin
    w_an_next = 4'b1111;
    w_digit   = 4'd0;
    w_blank   = 1'b1;
    case (r_slot)
      SLOT_ONES: begin w_an_next = 4'b1110; w_digit = r_shd_o; w_blank = 1'b0;    end
      SLOT_TENS: begin w_an_next = 4'b1101; w_digit = r_shd_t; w_blank = w_lzb_t; end
      SLOT_HUND: begin w_an_next = 4'b1011; w_digit = r_shd_h; w_blank = w_lzb_h; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= 4'b1111;
      r_seg        <= 7'h7F;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_next;
      r_seg        <= w_blank ? 7'h7F : seg_code(w_digit);
      r_frame_done <= w_commit;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = 1'b1;
  assign bus.frame_done = r_frame_done;
  assign bus.dbg_slot   = r_slot;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display, checked against a cycle-count reference model.
module tb_bcd_scan_display;

  localparam int DIV = 4;
`ifdef LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] SEG_TAB [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  bcd_scan_display_if bus ();

  bcd_scan_display #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Edge k after reset release: slot = (k/DIV)%4; outputs after edge k show that slot with
  // the shadow digits held before the edge. A frame boundary is the last cycle of slot 3.
  int         m_k;
  int         m_sh[3];
  int         m_pd[3];
  bit         m_pf;
  logic [11:0] exp_q[$];

  function automatic logic [6:0] model_seg(input int slot);
    if (slot == 3) return 7'h7F;
    if (LZB && slot == 2 && m_sh[2] == 0) return 7'h7F;
    if (LZB && slot == 1 && m_sh[2] == 0 && m_sh[1] == 0) return 7'h7F;
    return SEG_TAB[m_sh[slot]];
  endfunction

  always @(posedge clk) begin
    int  slot;
    bit  bnd;
    logic [3:0] an_e;
    if (!rst_n) begin
      m_k  = 0;
      m_sh = '{0, 0, 0};
      m_pd = '{0, 0, 0};
      m_pf = 1'b0;
      exp_q.push_back({4'hF, 7'h7F, 1'b0});
    end else begin
      slot = (m_k / DIV) % 4;
      bnd  = (m_k % DIV == DIV - 1) && (slot == 3);
      an_e = (slot < 3) ? ~(4'b0001 << slot) : 4'hF;
      exp_q.push_back({an_e, model_seg(slot), bnd});
      if (bus.load && bnd) begin
        m_sh = '{int'(bus.ones), int'(bus.tens), int'(bus.hundreds)};
        m_pf = 1'b0;
      end else if (bus.load) begin
        m_pd = '{int'(bus.ones), int'(bus.tens), int'(bus.hundreds)};
        m_pf = 1'b1;
      end else if (bnd && m_pf) begin
        m_sh = m_pd;
        m_pf = 1'b0;
      end
      m_k++;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan", {20'd0, bus.an, bus.seg, bus.frame_done}, {20'd0, e});
      check("dp", {31'd0, bus.dp}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    bus.load = 1'b1; bus.hundreds = h; bus.tens = t; bus.ones = o;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Returns at a negedge where the next rising edge is in slot s (or is the frame boundary).
  task automatic wait_slot(input int s, input bit boundary);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (((m_k / DIV) % 4 == s) && (!boundary || (m_k % DIV == DIV - 1))) return;
    end
    check("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd_cnt;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.hundreds = '0; bus.tens = '0; bus.ones = '0;

    repeat (3) @(negedge clk);
    check("rst_an",  {28'd0, bus.an},          32'hF);
    check("rst_seg", {25'd0, bus.seg},         32'h7F);
    check("rst_fd",  {31'd0, bus.frame_done},  32'd0);
    rst_n = 1'b1;
    idle(20);

    // 2,5,5 loaded during slot 0
    wait_slot(0, 1'b0);
    bus.load = 1'b1; bus.hundreds = 4'd2; bus.tens = 4'd5; bus.ones = 4'd5;
    @(negedge clk); bus.load = 1'b0;
    idle(40);

    // frame_done: exactly one pulse per 16-cycle frame
    fd_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (bus.frame_done) fd_cnt++;
    end
    check("fd_count", fd_cnt, 32'd10);

    // two loads in one frame: last wins
    wait_slot(0, 1'b0);
    drive_load(4'd1, 4'd2, 4'd3);
    drive_load(4'd4, 4'd5, 4'd6);
    idle(40);

    // dash and leading zeros
    drive_load(4'd0, 4'd0, 4'd12);
    idle(40);
    drive_load(4'd0, 4'd0, 4'd7);
    idle(40);
    drive_load(4'd0, 4'd3, 4'd0);
    idle(40);

    // load coincident with the frame boundary
    wait_slot(3, 1'b1);
    bus.load = 1'b1; bus.hundreds = 4'd7; bus.tens = 4'd8; bus.ones = 4'd9;
    @(negedge clk); bus.load = 1'b0;
    idle(20);

    // reset mid-frame in slot 2 with a pending load
    wait_slot(2, 1'b0);
    bus.load = 1'b1; bus.hundreds = 4'd9; bus.tens = 4'd9; bus.ones = 4'd9;
    @(posedge clk);
    #1 bus.load = 1'b0;
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_an",  {28'd0, bus.an},         32'hF);
    check("mid_rst_seg", {25'd0, bus.seg},        32'h7F);
    check("mid_rst_fd",  {31'd0, bus.frame_done}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(40);

    // randomized loads, some on frame boundaries
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        bus.load     = 1'b1;
        bus.hundreds = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.tens     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.ones     = 4'($urandom_range(0, 15));
      end else begin
        bus.load = 1'b0;
      end
    end
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_slot(3, 1'b1);
      bus.load = 1'b1;
      bus.hundreds = 4'($urandom_range(0, 9));
      bus.tens     = 4'($urandom_range(0, 9));
      bus.ones     = 4'($urandom_range(0, 9));
      @(negedge clk); bus.load = 1'b0;
      idle(int'($urandom_range(1, 20)));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Downstream consumer of the binary-to-BCD converter. Takes three BCD digits (hundreds/tens/ones) and drives a 4-digit, common-anode, time-multiplexed 7-segment display. Contains:
- a refresh prescaler
- a digit-scan counter
- double-buffered digit registers, so a display update never tears mid-frame
- registered segment/anode decode

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= 2.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  single-cycle strobe; capture hundreds/tens/ones this cycle.
hundreds  input  4  BCD hundreds digit.
tens  input  4  BCD tens digit.
ones  input  4  BCD ones digit.
seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
an  output  4  anode enables, active-low; an[0]=rightmost digit.
dp  output  1  decimal point, active-low; held 1 (off).
frame_done  output  1  one-cycle pulse when the scan wraps slot 3 -> 0.

Behaviour:
- Reset (async, rst_n=0), all values apply immediately and are held until release:
  - prescaler=0, slot index=0, pending flag=0, pending and shadow digits=0
  - an=4'b1111, seg=7'h7F, dp=1, frame_done=0
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0. "tick" is high on the cycle the count equals REFRESH_DIV-1.
- Slot index (2 bits) advances 0->1->2->3->0 on each tick.
- Slot mapping:
  - slot 0: ones on an[0]
  - slot 1: tens on an[1]
  - slot 2: hundreds on an[2]
  - slot 3: blank slot with an=4'b1111 and seg=7'h7F; keeps the 25% duty of a 4-digit board.
- an and seg are registered and reflect the slot index one clock after the index changes. Exactly one anode is low in slots 0-2.
- Double buffering:
  - load=1 copies the inputs into pending registers and sets the pending flag. A later load before commit overwrites pending (last wins).
  - Commit happens at the frame boundary, i.e. a tick while slot=3. If the pending flag is set, shadow <= pending and the flag clears.
  - If load and the frame boundary occur in the same cycle, the inputs of that cycle go straight to shadow and the flag stays 0.
  - Decode reads shadow only.
- frame_done is a registered pulse, high for exactly one cycle, on the cycle after the slot 3 -> 0 tick.
- Segment codes (active-low, hex of {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - any digit value 10-15 displays a dash, 3F
  - blank = 7F
- No handshake backpressure: load is always accepted.

Optional Feature:
LZB_EN (leading-zero blanking).
- Defined: hundreds slot shows blank (7F) when shadow hundreds==0. Tens slot shows blank when shadow hundreds==0 and shadow tens==0. Ones is never blanked, so value 0 shows "0".
- Undefined: all three digits are always displayed, including leading zeros.
- The anode timing is identical in both builds; only seg changes.

Test Plan:
1. Reset with REFRESH_DIV=4: hold rst_n=0 -> an=1111, seg=7F, dp=1, frame_done=0. Release -> first an=1110 appears with seg=40 (shadow=0).
2. load with 2,5,5 during slot 0, REFRESH_DIV=4 -> display unchanged until the first frame boundary. Next frame: an=1110/seg=12, an=1101/seg=12, an=1011/seg=24, then an=1111/seg=7F. frame_done pulses once per 16 cycles.
3. Two loads in one frame, (1,2,3) then (4,5,6) -> the next frame shows only 6/5/4 (seg 02/12/19). The same frame never shows a mix of the two loads.
4. load (0,0,12) -> ones slot seg=3F (dash). Hundreds and tens show 40 without LZB_EN, 7F with LZB_EN. With LZB_EN and load (0,0,7): hundreds=7F, tens=7F, ones=78.
5. Reset asserted mid-frame in slot 2 with a pending load -> outputs go to reset values within the same cycle. After release, shadow=0 and the pending load is discarded (seg=40 on slot 0).
6. load coincident with the slot-3 tick (7,8,9) -> the following slots 0/1/2 show seg 10/00/78 in the immediately next frame.
